// File: rtl/branch_unit_pkg.sv
// Shared condition codes, branch-type codes and PSR bit positions for the
// microsequencer branch unit.
package branch_unit_pkg;

  localparam logic [3:0] COND_NEXT   = 4'b0000;
  localparam logic [3:0] COND_N      = 4'b0001;
  localparam logic [3:0] COND_Z      = 4'b0010;
  localparam logic [3:0] COND_V      = 4'b0011;
  localparam logic [3:0] COND_C      = 4'b0100;
  localparam logic [3:0] COND_IR13   = 4'b0101;
  localparam logic [3:0] COND_ALWAYS = 4'b0110;
  localparam logic [3:0] COND_DECODE = 4'b0111;
  localparam logic [3:0] COND_NN     = 4'b1000;
  localparam logic [3:0] COND_NZ     = 4'b1001;
  localparam logic [3:0] COND_NV     = 4'b1010;
  localparam logic [3:0] COND_NC     = 4'b1011;
  localparam logic [3:0] COND_NIR13  = 4'b1100;
  localparam logic [3:0] COND_LOOP   = 4'b1101;
  localparam logic [3:0] COND_LT     = 4'b1110;
  localparam logic [3:0] COND_LEU    = 4'b1111;

  localparam logic [1:0] TIPO_NEXT   = 2'b00;
  localparam logic [1:0] TIPO_JUMP   = 2'b01;
  localparam logic [1:0] TIPO_DECODE = 2'b10;

  localparam int unsigned PSR_N = 3;
  localparam int unsigned PSR_Z = 2;
  localparam int unsigned PSR_V = 1;
  localparam int unsigned PSR_C = 0;

endpackage

// File: rtl/branch_unit_seq_loop.sv
// Microcode loop counter: load has priority, otherwise decrements on an
// evaluated LOOP condition that is taken; never wraps below zero.
module branch_loop_counter #(
  parameter int unsigned LOOP = 6
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            load,
  input  logic [LOOP-1:0] loadValue,
  input  logic            decReq,
  input  logic            take,
  output logic [LOOP-1:0] count,
  output logic            zero
);

  // Counter register: reset, load, conditional decrement, else hold
  always_ff @(posedge clk) begin
    if (!rstN) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (decReq && take) begin
      count <= count - LOOP'(1);
    end
  end

  // Zero flag straight off the register
  assign zero = (count == '0);

endmodule

// File: rtl/branch_unit_seq.sv
// Registered branch unit: PSR register, condition mux and branch-type output
// register; loop counting lives in branch_loop_counter.
module branch_unit_seq
  import branch_unit_pkg::*;
#(
  parameter int unsigned BRANCH_UNIT_PSR       = 4,
  parameter int unsigned BRANCH_UNIT_CONDITION = 4,
  parameter int unsigned BRANCH_UNIT_TIPO      = 2,
  parameter int unsigned BRANCH_UNIT_LOOP      = 6
) (
  input  logic                             BRANCH_UNIT_CLOCK_50,
  input  logic                             BRANCH_UNIT_ResetInLow_In,
  input  logic                             BRANCH_UNIT_Evaluate_In,
  input  logic [BRANCH_UNIT_CONDITION-1:0] BRANCH_UNIT_Condition_InBus,
  input  logic                             BRANCH_UNIT_IR13_In,
  input  logic [BRANCH_UNIT_PSR-1:0]       BRANCH_UNIT_AluFlags_InBus,
  input  logic                             BRANCH_UNIT_PsrWrite_In,
  input  logic                             BRANCH_UNIT_LoopLoad_In,
  input  logic [BRANCH_UNIT_LOOP-1:0]      BRANCH_UNIT_LoopValue_InBus,
  output logic [BRANCH_UNIT_TIPO-1:0]      BRANCH_UNIT_Tipo_OutBus,
  output logic                             BRANCH_UNIT_Valid_Out,
  output logic [BRANCH_UNIT_PSR-1:0]       BRANCH_UNIT_Psr_OutBus,
  output logic [BRANCH_UNIT_LOOP-1:0]      BRANCH_UNIT_LoopCount_OutBus,
  output logic                             BRANCH_UNIT_LoopZero_Out
);

  logic [BRANCH_UNIT_PSR-1:0]  psrReg;
  logic [BRANCH_UNIT_TIPO-1:0] tipoReg;
  logic [BRANCH_UNIT_TIPO-1:0] tipoNext;
  logic                        validReg;
  logic                        take;
  logic                        loopZero;
  logic                        loopDecReq;

  // Condition mux on the pre-edge PSR and loop count
  always_comb begin
    take = 1'b0;
    unique case (BRANCH_UNIT_Condition_InBus)
      COND_NEXT:   take = 1'b0;
      COND_N:      take = psrReg[PSR_N];
      COND_Z:      take = psrReg[PSR_Z];
      COND_V:      take = psrReg[PSR_V];
      COND_C:      take = psrReg[PSR_C];
      COND_IR13:   take = BRANCH_UNIT_IR13_In;
      COND_ALWAYS: take = 1'b1;
      COND_DECODE: take = 1'b0;
      COND_NN:     take = !psrReg[PSR_N];
      COND_NZ:     take = !psrReg[PSR_Z];
      COND_NV:     take = !psrReg[PSR_V];
      COND_NC:     take = !psrReg[PSR_C];
      COND_NIR13:  take = !BRANCH_UNIT_IR13_In;
      COND_LOOP:   take = !loopZero;
      COND_LT:     take = psrReg[PSR_N] ^ psrReg[PSR_V];
      COND_LEU:    take = psrReg[PSR_C] | psrReg[PSR_Z];
      default:     take = 1'b0;
    endcase
    if (BRANCH_UNIT_Condition_InBus == COND_DECODE) begin
      tipoNext = TIPO_DECODE;
    end else begin
      tipoNext = take ? TIPO_JUMP : TIPO_NEXT;
    end
    loopDecReq = BRANCH_UNIT_Evaluate_In &&
                 (BRANCH_UNIT_Condition_InBus == COND_LOOP);
  end

  // Output and PSR registers
  always_ff @(posedge BRANCH_UNIT_CLOCK_50) begin
    if (!BRANCH_UNIT_ResetInLow_In) begin
      tipoReg  <= TIPO_NEXT;
      validReg <= 1'b0;
      psrReg   <= '0;
    end else begin
      validReg <= BRANCH_UNIT_Evaluate_In;
      tipoReg  <= BRANCH_UNIT_Evaluate_In ? tipoNext : TIPO_NEXT;
      if (BRANCH_UNIT_PsrWrite_In) begin
        psrReg <= BRANCH_UNIT_AluFlags_InBus;
      end
    end
  end

  branch_loop_counter #(
    .LOOP(BRANCH_UNIT_LOOP)
  ) uLoop (
    .clk       (BRANCH_UNIT_CLOCK_50),
    .rstN      (BRANCH_UNIT_ResetInLow_In),
    .load      (BRANCH_UNIT_LoopLoad_In),
    .loadValue (BRANCH_UNIT_LoopValue_InBus),
    .decReq    (loopDecReq),
    .take      (!loopZero),
    .count     (BRANCH_UNIT_LoopCount_OutBus),
    .zero      (loopZero)
  );

  assign BRANCH_UNIT_Tipo_OutBus  = tipoReg;
  assign BRANCH_UNIT_Valid_Out    = validReg;
  assign BRANCH_UNIT_Psr_OutBus   = psrReg;
  assign BRANCH_UNIT_LoopZero_Out = loopZero;

endmodule

// File: tb/tb_branch_unit_seq.sv
// Testbench for branch_unit_seq: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_branch_unit_seq;

  logic       clk = 1'b0;
  logic       rstN;
  logic       ev;
  logic [3:0] cond;
  logic       ir13;
  logic [3:0] flags;
  logic       psrWrite;
  logic       loopLoad;
  logic [5:0] loopVal;
  logic [1:0] tipo;
  logic       valid;
  logic [3:0] psr;
  logic [5:0] count;
  logic       loopZero;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  int mPsr   = 0;
  int mCount = 0;
  int eTipo  = 0;
  int eValid = 0;

  always #5 clk = ~clk;

  branch_unit_seq #(
    .BRANCH_UNIT_PSR(4),
    .BRANCH_UNIT_CONDITION(4),
    .BRANCH_UNIT_TIPO(2),
    .BRANCH_UNIT_LOOP(6)
  ) dut (
    .BRANCH_UNIT_CLOCK_50        (clk),
    .BRANCH_UNIT_ResetInLow_In   (rstN),
    .BRANCH_UNIT_Evaluate_In     (ev),
    .BRANCH_UNIT_Condition_InBus (cond),
    .BRANCH_UNIT_IR13_In         (ir13),
    .BRANCH_UNIT_AluFlags_InBus  (flags),
    .BRANCH_UNIT_PsrWrite_In     (psrWrite),
    .BRANCH_UNIT_LoopLoad_In     (loopLoad),
    .BRANCH_UNIT_LoopValue_InBus (loopVal),
    .BRANCH_UNIT_Tipo_OutBus     (tipo),
    .BRANCH_UNIT_Valid_Out       (valid),
    .BRANCH_UNIT_Psr_OutBus      (psr),
    .BRANCH_UNIT_LoopCount_OutBus(count),
    .BRANCH_UNIT_LoopZero_Out    (loopZero)
  );

  function automatic int condTaken(int c, int p, int cnt, int ir);
    int n, z, v, cy;
    n  = (p >> 3) % 2;
    z  = (p >> 2) % 2;
    v  = (p >> 1) % 2;
    cy = p % 2;
    case (c)
      1:  return n;
      2:  return z;
      3:  return v;
      4:  return cy;
      5:  return ir;
      6:  return 1;
      8:  return 1 - n;
      9:  return 1 - z;
      10: return 1 - v;
      11: return 1 - cy;
      12: return 1 - ir;
      13: return (cnt > 0) ? 1 : 0;
      14: return (n != v) ? 1 : 0;
      15: return (cy + z > 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Advance one clock: update the model from pre-edge state, then sample 1ns after
  task automatic cycle();
    int t;
    if (!rstN) begin
      eTipo = 0; eValid = 0; mPsr = 0; mCount = 0;
    end else begin
      eValid = ev ? 1 : 0;
      if (!ev) eTipo = 0;
      else if (cond == 4'd7) eTipo = 2;
      else begin
        t = condTaken(int'(cond), mPsr, mCount, int'(ir13));
        eTipo = t;
      end
      if (loopLoad) mCount = int'(loopVal);
      else if (ev && cond == 4'd13 && mCount > 0) mCount = mCount - 1;
      if (psrWrite) mPsr = int'(flags);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rstN = 1'b1; ev = 1'b0; cond = 4'd0; ir13 = 1'b0; flags = 4'd0;
    psrWrite = 1'b0; loopLoad = 1'b0; loopVal = 6'd0;
  endtask

  task automatic test_reset();
    idle();
    rstN = 1'b0; ev = 1'b1; cond = 4'b0110;
    for (int i = 0; i < 2; i++) begin
      cycle();
      tests++;
      if (tipo !== 2'b00 || valid !== 1'b0 || psr !== 4'd0 || loopZero !== 1'b1) begin
        fails++;
        $display("FAIL reset cyc%0d: tipo=%b valid=%b psr=%b lz=%b, want 00 0 0000 1",
                 i, tipo, valid, psr, loopZero);
      end
    end
    rstN = 1'b1;
    cycle();
    tests++;
    if (tipo !== 2'b01 || valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: tipo=%b valid=%b, want 01 1", tipo, valid);
    end
    // Reset while an evaluation is in flight drops the result
    rstN = 1'b0;
    cycle();
    tests++;
    if (valid !== 1'b0 || tipo !== 2'b00) begin
      fails++;
      $display("FAIL reset_mid_eval: tipo=%b valid=%b, want 00 0", tipo, valid);
    end
    idle();
    cycle();
  endtask

  task automatic test_flags();
    idle();
    psrWrite = 1'b1; flags = 4'b0100;
    cycle();
    idle();
    tests++;
    if (psr !== 4'b0100) begin
      fails++;
      $display("FAIL psr_load: psr=%b, want 0100", psr);
    end
    ev = 1'b1; cond = 4'b0010;
    cycle();
    tests++;
    if (tipo !== 2'b01 || valid !== 1'b1) begin
      fails++;
      $display("FAIL cond_z: tipo=%b valid=%b, want 01 1", tipo, valid);
    end
    cond = 4'b1001;
    cycle();
    tests++;
    if (tipo !== 2'b00 || valid !== 1'b1) begin
      fails++;
      $display("FAIL cond_nz: tipo=%b valid=%b, want 00 1", tipo, valid);
    end
    cond = 4'b0111;
    cycle();
    tests++;
    if (tipo !== 2'b10) begin
      fails++;
      $display("FAIL cond_decode: tipo=%b, want 10", tipo);
    end
    idle();
  endtask

  task automatic test_psr_race();
    idle();
    psrWrite = 1'b1; flags = 4'b1000;
    cycle();
    flags = 4'b0000; ev = 1'b1; cond = 4'b1110;
    cycle();
    tests++;
    if (tipo !== 2'b01 || psr !== 4'b0000) begin
      fails++;
      $display("FAIL lt_old_flags: tipo=%b psr=%b, want 01 0000", tipo, psr);
    end
    psrWrite = 1'b0;
    cycle();
    tests++;
    if (tipo !== 2'b00) begin
      fails++;
      $display("FAIL lt_new_flags: tipo=%b, want 00", tipo);
    end
    idle();
  endtask

  task automatic test_loop();
    logic [1:0] wantTipo [4];
    logic [5:0] wantCnt [4];
    logic       wantZ [4];
    wantTipo = '{2'b01, 2'b01, 2'b01, 2'b00};
    wantCnt  = '{6'd2, 6'd1, 6'd0, 6'd0};
    wantZ    = '{1'b0, 1'b0, 1'b1, 1'b1};
    idle();
    loopLoad = 1'b1; loopVal = 6'd3;
    cycle();
    idle();
    tests++;
    if (count !== 6'd3 || loopZero !== 1'b0) begin
      fails++;
      $display("FAIL loop_load: count=%0d lz=%b, want 3 0", count, loopZero);
    end
    ev = 1'b1; cond = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      cycle();
      tests++;
      if (tipo !== wantTipo[i] || count !== wantCnt[i] || loopZero !== wantZ[i]) begin
        fails++;
        $display("FAIL loop_step%0d: tipo=%b count=%0d lz=%b, want %b %0d %b",
                 i, tipo, count, loopZero, wantTipo[i], wantCnt[i], wantZ[i]);
      end
    end
    idle();
  endtask

  task automatic test_loop_load_race();
    idle();
    loopLoad = 1'b1; loopVal = 6'd2;
    cycle();
    loopVal = 6'd5; ev = 1'b1; cond = 4'b1101;
    cycle();
    tests++;
    if (tipo !== 2'b01 || count !== 6'd5) begin
      fails++;
      $display("FAIL loop_load_race: tipo=%b count=%0d, want 01 5", tipo, count);
    end
    idle();
    cycle();
    tests++;
    if (count !== 6'd5) begin
      fails++;
      $display("FAIL loop_hold: count=%0d, want 5", count);
    end
  endtask

  task automatic test_misc();
    idle();
    psrWrite = 1'b1; flags = 4'b0001;
    cycle();
    idle();
    ir13 = 1'b1; ev = 1'b1; cond = 4'b1111;
    cycle();
    tests++;
    if (tipo !== 2'b01) begin
      fails++;
      $display("FAIL cond_leu: tipo=%b, want 01", tipo);
    end
    cond = 4'b1100;
    cycle();
    tests++;
    if (tipo !== 2'b00) begin
      fails++;
      $display("FAIL cond_nir13: tipo=%b, want 00", tipo);
    end
    cond = 4'b0000;
    cycle();
    tests++;
    if (tipo !== 2'b00 || valid !== 1'b1) begin
      fails++;
      $display("FAIL cond_next: tipo=%b valid=%b, want 00 1", tipo, valid);
    end
    ev = 1'b0; cond = 4'b0110;
    cycle();
    tests++;
    if (tipo !== 2'b00 || valid !== 1'b0) begin
      fails++;
      $display("FAIL no_eval: tipo=%b valid=%b, want 00 0", tipo, valid);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rstN     = ($urandom_range(0, 39) != 0);
      ev       = ($urandom_range(0, 3) != 0);
      cond     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) cond = 4'd13;
      ir13     = 1'($urandom_range(0, 1));
      flags    = 4'($urandom_range(0, 15));
      psrWrite = ($urandom_range(0, 2) == 0);
      loopLoad = ($urandom_range(0, 9) == 0);
      loopVal  = 6'($urandom_range(0, 7));
      cycle();
      tests++;
      if (int'(tipo) != eTipo || int'(valid) != eValid || int'(psr) != mPsr ||
          int'(count) != mCount || loopZero !== (mCount == 0)) begin
        fails++;
        $display("FAIL random%0d: tipo=%b valid=%b psr=%b cnt=%0d lz=%b, want %0d %0d %0d %0d %0d",
                 i, tipo, valid, psr, count, loopZero, eTipo, eValid, mPsr, mCount,
                 (mCount == 0));
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rstN = 1'b0;
    #1;
    test_reset();
    test_flags();
    test_psr_race();
    test_loop();
    test_loop_load_race();
    test_misc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
